// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter_ctrl block: FSM state encoding,
// direction codes and the owner-index width helper.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // The owner index is at least one bit wide even for a single requester.
  function automatic int owner_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// Requester-side bundle of counter_ctrl: per-requester command handshake plus
// the shared counter status seen by all requesters.
interface counter_ctrl_if #(
  parameter int WIDTH = 3,
  parameter int LEN_W = 4,
  parameter int NREQ  = 2
);
  import counter_ctrl_pkg::*;

  localparam int OWN_W = owner_w(NREQ);

  // Handshake: requester i holds req_valid[i] with stable req_dir[i] and
  // req_len[i*LEN_W +: LEN_W] until the edge where req_ready[i] is also high;
  // that edge takes the command. req_ready is one-hot and only set in IDLE.
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_dir;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [NREQ-1:0]       req_ready;
  logic                  clr;
  logic [WIDTH-1:0]      count;
  logic                  busy;
  logic [OWN_W-1:0]      owner;
  logic                  done;

  modport master (
    output req_valid, req_dir, req_len, clr,
    input  req_ready, count, busy, owner, done
  );

  modport slave (
    input  req_valid, req_dir, req_len, clr,
    output req_ready, count, busy, owner, done
  );

endinterface

// File: rtl/counter_ctrl_updown_counter.sv
// Up/down counter datapath owned by counter_ctrl. Wraps modulo 2^WIDTH by
// default; defining COUNTER_CTRL_SAT_EN makes it saturate at 0 and 2^WIDTH-1.
module updown_counter
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // clr wins over a step on the same edge.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      if (dir == DIR_UP) begin
`ifdef COUNTER_CTRL_SAT_EN
        count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;
`else
        count_d = count_q + CNT_ONE;
`endif
      end else begin
`ifdef COUNTER_CTRL_SAT_EN
        count_d = (count_q == '0) ? count_q : count_q - CNT_ONE;
`else
        count_d = count_q - CNT_ONE;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_ctrl.sv
// Round-robin controller sharing one up/down counter between NREQ requesters.
// Build option: COUNTER_CTRL_SAT_EN selects saturating instead of wrapping counts.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int LEN_W = 4,
  parameter int NREQ  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  counter_ctrl_if.slave  bus,
  output state_e         dbg_state
);

  localparam int OWN_W = owner_w(NREQ);
  localparam logic [OWN_W-1:0] LAST_RST = OWN_W'(NREQ - 1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  state_e            state_q, state_d;
  logic              dir_q, dir_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [OWN_W-1:0]  owner_q, owner_d;
  logic [OWN_W-1:0]  last_q, last_d;

  logic              found;
  logic [OWN_W-1:0]  winner;
  logic              dir_sel;
  logic [LEN_W-1:0]  len_sel;
  logic [NREQ-1:0]   ready;
  logic              step_en;
  logic              done;
  logic [WIDTH-1:0]  count_w;

  // Search starts one past the last grant and wraps, so every requester that
  // stays valid is served within NREQ grants.
  always_comb begin : arb
    int idx;
    logic [OWN_W-1:0] idx_o;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    idx_o  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      idx_o = OWN_W'(idx);
      if (!found && bus.req_valid[idx_o]) begin
        found  = 1'b1;
        winner = idx_o;
      end
    end
  end

  always_comb begin : field_mux
    dir_sel = DIR_DN;
    len_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == OWN_W'(i)) begin
        dir_sel = bus.req_dir[i];
        len_sel = bus.req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  always_comb begin : fsm_next
    state_d = state_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    owner_d = owner_q;
    last_d  = last_q;
    ready   = '0;
    step_en = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          ready[winner] = 1'b1;
          dir_d   = dir_sel;
          rem_d   = len_sel;
          owner_d = winner;
          last_d  = winner;
          state_d = (len_sel != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        // remaining still counts down when clr overrides the step, so done
        // timing depends only on the accepted length.
        step_en = 1'b1;
        rem_d   = rem_q - LEN_ONE;
        if (rem_q == LEN_ONE) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= DIR_DN;
      rem_q   <= '0;
      owner_q <= '0;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  updown_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (step_en),
    .dir   (dir_q),
    .clr   (bus.clr),
    .count (count_w)
  );

  assign bus.req_ready = ready;
  assign bus.count     = count_w;
  assign bus.busy      = (state_q != IDLE);
  assign bus.owner     = owner_q;
  assign bus.done      = done;
  assign dbg_state     = state_q;

`ifndef SYNTHESIS
  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(ready));
  a_run_rem: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == RUN) |-> (rem_q != '0));
  a_ready_idle: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != IDLE) |-> (ready == '0));
`endif

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: expected counts and done owners are
// queued when a command is driven and compared as the DUT produces them.
module tb_counter_ctrl;
  import counter_ctrl_pkg::*;

  localparam int WIDTH = 3;
  localparam int LEN_W = 4;
  localparam int NREQ  = 2;

  // ---------------- clock / reset ----------------
  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  state_e dbg_state;

  always #5 clk = ~clk;

  counter_ctrl_if #(.WIDTH(WIDTH), .LEN_W(LEN_W), .NREQ(NREQ)) bus();

  counter_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  int               own_q[$];
  logic [WIDTH-1:0] model_count = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] step_model(input logic [WIDTH-1:0] c, input logic d);
    logic [WIDTH-1:0] one;
    one = WIDTH'(1);
`ifdef COUNTER_CTRL_SAT_EN
    if (d) return (c == {WIDTH{1'b1}}) ? c : c + one;
    else   return (c == '0) ? c : c - one;
`else
    return d ? c + one : c - one;
`endif
  endfunction

  // Every done pulse must match the owner queued at its accept.
  always @(posedge clk) begin
    #1;
    if (rst_n && bus.done) begin
      if (own_q.size() == 0) check("spurious_done", 1, 0);
      else                   check("done_owner", bus.owner, own_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_cmd(input int r, input logic d, input int len, input int clr_edge,
                         output int acc_cyc);
    logic [WIDTH-1:0] m;
    int waited;
    acc_cyc = -1;
    @(negedge clk);
    bus.req_valid[r] = 1'b1;
    bus.req_dir[r]   = d;
    bus.req_len[r*LEN_W +: LEN_W] = LEN_W'(len);
    waited = 0;
    #1;
    while (bus.req_ready == '0 && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    if (bus.req_ready == '0) begin
      check("ready_timeout", 0, 1);
      bus.req_valid[r] = 1'b0;
      return;
    end
    check("ready_onehot", bus.req_ready, 32'(1) << r);
    m = model_count;
    for (int k = 1; k <= len; k++) begin
      m = (k == clr_edge) ? '0 : step_model(m, d);
      exp_q.push_back(m);
    end
    own_q.push_back(r);
    @(posedge clk); #1;
    acc_cyc = cyc;
    bus.req_valid[r] = 1'b0;
    check("busy_rise", bus.busy, 1);
    check("owner", bus.owner, r);
    if (len == 0) begin
      check("len0_done", bus.done, 1);
      check("len0_count", bus.count, model_count);
    end
    for (int k = 1; k <= len; k++) begin
      if (k == clr_edge) bus.clr = 1'b1;
      @(posedge clk); #1;
      bus.clr = 1'b0;
      check("count_step", bus.count, exp_q.pop_front());
      check("done_timing", bus.done, (k == len) ? 1 : 0);
    end
    model_count = m;
    @(posedge clk); #1;
    check("done_clear", bus.done, 0);
    check("busy_fall", bus.busy, 0);
  endtask

  task automatic clr_idle();
    @(negedge clk);
    bus.clr = 1'b1;
    @(posedge clk); #1;
    bus.clr = 1'b0;
    model_count = '0;
    check("clr_idle", bus.count, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int a1, a2, g, last, waited;
    logic [WIDTH-1:0] m;
    bus.req_valid = '0;
    bus.req_dir   = '0;
    bus.req_len   = '0;
    bus.clr       = 1'b0;

    // Reset values, during and after reset.
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", bus.count, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ready", bus.req_ready, 0);
    check("rst_owner", bus.owner, 0);
    check("rst_state", dbg_state, IDLE);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_count", bus.count, 0);
    check("post_rst_ready", bus.req_ready, 0);
    check("post_rst_busy", bus.busy, 0);

    // req0 up by 5.
    run_cmd(0, DIR_UP, 5, 0, a1);

    // req1 up by 10 from 0: wraps to 2 (or holds at 7 when saturating).
    clr_idle();
    run_cmd(1, DIR_UP, 10, 0, a1);
`ifdef COUNTER_CTRL_SAT_EN
    check("len10_final", bus.count, 7);
`else
    check("len10_final", bus.count, 2);
`endif

    // Both requesters continuously valid, len=1: grants 0,1,0,1 three cycles apart.
    @(negedge clk);
    bus.req_len   = {LEN_W'(1), LEN_W'(1)};
    bus.req_dir   = {DIR_UP, DIR_UP};
    bus.req_valid = 2'b11;
    g = 0; waited = 0; last = 0;
    while (g < 4 && waited < 60) begin
      #1;
      check("ready_onehot0", ($countones(bus.req_ready) <= 1) ? 1 : 0, 1);
      if (bus.req_ready != '0) begin
        check("rr_grant", bus.req_ready, 32'(1) << (g % 2));
        if (g > 0) check("rr_spacing", cyc - last, 3);
        own_q.push_back(g % 2);
        last = cyc;
        g++;
      end
      @(negedge clk);
      waited++;
    end
    check("rr_grants", g, 4);
    bus.req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    m = model_count;
    for (int k = 0; k < 4; k++) m = step_model(m, DIR_UP);
    model_count = m;
    check("rr_count", bus.count, model_count);

    // req0 down len=0 twice: count unchanged, accepts two cycles apart.
    run_cmd(0, DIR_DN, 0, 0, a1);
    run_cmd(0, DIR_DN, 0, 0, a2);
    check("len0_spacing", a2 - a1, 2);

    // Reset pulsed mid-RUN at step 3 of a len=8 up command.
    clr_idle();
    @(negedge clk);
    bus.req_valid[0] = 1'b1;
    bus.req_dir[0]   = DIR_UP;
    bus.req_len[0 +: LEN_W] = LEN_W'(8);
    #1;
    waited = 0;
    while (bus.req_ready[0] !== 1'b1 && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    check("abort_ready", bus.req_ready, 1);
    own_q.push_back(0);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_pre", bus.count, 3);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("abort_count", bus.count, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_state", dbg_state, IDLE);
    check("abort_no_done", own_q.size(), 1);
    own_q.delete();
    model_count = '0;
    @(negedge clk) rst_n = 1'b1;

    // clr during RUN at count=4; stepping resumes from 0, done on edge 6.
    run_cmd(0, DIR_UP, 6, 5, a1);
    check("clr_run_final", bus.count, 1);

    // Random single-requester commands.
    repeat (8) begin
      run_cmd($urandom_range(0, NREQ - 1), logic'($urandom_range(0, 1)),
              $urandom_range(0, 12), 0, a1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("exp_q_empty", exp_q.size(), 0);
    check("own_q_empty", own_q.size(), 0);
    check("final_count", bus.count, model_count);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
